// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, datapath select enums and FSM states.
package cpu_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;
    typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10} result_src_e;
    typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10} srca_e;
    typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} srcb_e;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEM_RD, MEM_WB, MEM_WR,
        EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, TRAP
    } ctrl_state_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the sequencer, slave is the datapath side.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_we;
    logic        pc_we;
    logic        pc_src;
    logic        reg_write;
    logic [1:0]  alu_srca;
    logic [1:0]  alu_srcb;
    logic [2:0]  alu_ctrl;
    logic [1:0]  imm_src;
    logic [1:0]  result_src;
    logic        illegal;
    logic        bus_err;

    modport master (
        input  instr, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_write,
               alu_srca, alu_srcb, alu_ctrl, imm_src, result_src, illegal, bus_err
    );

    modport slave (
        output instr, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_write,
               alu_srca, alu_srcb, alu_ctrl, imm_src, result_src, illegal, bus_err
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps funct3/funct7[30] to an ALU operation for R/I-type execution; flags unsupported funct3.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic       op_r,
    input  logic [2:0] f3,
    input  logic       f7b5,
    output alu_ctrl_e  alu_ctrl,
    output logic       bad_f3
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        bad_f3   = 1'b0;
        case (f3)
            3'b000:  alu_ctrl = (op_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_ctrl = ALU_AND;
            3'b110:  alu_ctrl = ALU_OR;
            3'b010:  alu_ctrl = ALU_SLT;
            default: bad_f3   = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: state register, next-state/output decode, memory wait timeout, sticky traps.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst,
    multicycle_ctrl_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    ctrl_state_e   state, state_nx;
    logic [CW-1:0] wait_cnt;
    logic          illegal_q, bus_err_q;
    logic          set_illegal, set_bus_err;
    logic          waiting, timed_out, bad_f3;
    alu_ctrl_e     exec_alu;
    logic [6:0]    opcode;
    logic [2:0]    f3;

    assign opcode = bus.instr[6:0];
    assign f3     = bus.instr[14:12];

    alu_decoder u_alu_dec (
        .op_r     (state == EXEC_R),
        .f3       (f3),
        .f7b5     (bus.instr[30]),
        .alu_ctrl (exec_alu),
        .bad_f3   (bad_f3)
    );

    // A ready in the last allowed wait cycle still completes the access.
    assign waiting   = (state == FETCH || state == MEM_RD || state == MEM_WR) && !bus.mem_ready;
    assign timed_out = waiting && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) wait_cnt <= '0;
            else if (waiting)      wait_cnt <= wait_cnt + CW'(1);
            if (set_illegal) illegal_q <= 1'b1;
            if (set_bus_err) bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx       = state;
        set_illegal    = 1'b0;
        set_bus_err    = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_srca   = SRCA_PC;
        bus.alu_srcb   = SRCB_RS2;
        bus.alu_ctrl   = ALU_ADD;
        bus.imm_src    = IMM_I;
        bus.result_src = RES_ALUOUT;
        bus.illegal    = illegal_q;
        bus.bus_err    = bus_err_q;
        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_we    = 1'b1;
                    bus.pc_we    = 1'b1;
                    bus.alu_srcb = SRCB_FOUR;
                    state_nx     = DECODE;
                end else if (timed_out) begin
                    set_bus_err = 1'b1;
                    state_nx    = TRAP;
                end
            end
            DECODE: begin
                bus.alu_srca = SRCA_OLDPC;
                bus.alu_srcb = SRCB_IMM;
                bus.imm_src  = IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_nx = MEMADR;
                    OP_R:              state_nx = EXEC_R;
                    OP_I:              state_nx = EXEC_I;
                    OP_BRANCH:         state_nx = BRANCH;
                    OP_JAL:            state_nx = JAL;
                    default: begin
                        set_illegal = 1'b1;
                        state_nx    = TRAP;
                    end
                endcase
            end
            MEMADR: begin
                bus.alu_srca = SRCA_RS1;
                bus.alu_srcb = SRCB_IMM;
                bus.imm_src  = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_nx     = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
            end
            MEM_RD, MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                bus.mem_we  = (state == MEM_WR);
                if (bus.mem_ready) begin
                    state_nx = (state == MEM_WR) ? FETCH : MEM_WB;
                end else if (timed_out) begin
                    set_bus_err = 1'b1;
                    state_nx    = TRAP;
                end
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.result_src = RES_MEM;
                state_nx       = FETCH;
            end
            EXEC_R, EXEC_I: begin
                bus.alu_srca = SRCA_RS1;
                bus.alu_srcb = (state == EXEC_I) ? SRCB_IMM : SRCB_RS2;
                bus.alu_ctrl = exec_alu;
                if (bad_f3) begin
                    set_illegal = 1'b1;
                    state_nx    = TRAP;
                end else begin
                    state_nx = ALU_WB;
                end
            end
            ALU_WB: begin
                bus.reg_write = 1'b1;
                state_nx      = FETCH;
            end
            BRANCH: begin
                bus.alu_srca = SRCA_RS1;
                bus.alu_ctrl = ALU_SUB;
                bus.pc_src   = 1'b1;
                state_nx     = FETCH;
                case (f3)
                    3'b000:  bus.pc_we = bus.zero;
                    3'b001:  bus.pc_we = !bus.zero;
                    default: begin
                        set_illegal = 1'b1;
                        state_nx    = TRAP;
                    end
                endcase
            end
            JAL: begin
                bus.pc_we      = 1'b1;
                bus.pc_src     = 1'b1;
                bus.alu_srca   = SRCA_OLDPC;
                bus.alu_srcb   = SRCB_FOUR;
                bus.result_src = RES_ALU;
                bus.reg_write  = 1'b1;
                state_nx       = FETCH;
            end
            TRAP:    state_nx = TRAP;
            default: state_nx = IDLE;
        endcase
        // Reset silences every output immediately, including an in-flight memory request.
        if (!rst) begin
            bus.mem_req    = 1'b0;
            bus.mem_we     = 1'b0;
            bus.iord       = 1'b0;
            bus.ir_we      = 1'b0;
            bus.pc_we      = 1'b0;
            bus.pc_src     = 1'b0;
            bus.reg_write  = 1'b0;
            bus.alu_srca   = 2'b00;
            bus.alu_srcb   = 2'b00;
            bus.alu_ctrl   = 3'b000;
            bus.imm_src    = 2'b00;
            bus.result_src = 2'b00;
            bus.illegal    = 1'b0;
            bus.bus_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus a random instruction stream against an instruction-level model.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_nx = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // memory responder state
    int   fix_wait = 0;
    bit   hang = 0;
    bit   busy = 0;
    int   rem = 0;
    int   cur_wait = 0;
    bit   prev_wait = 0;
    logic [2:0] prev_rq = 3'b0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] outs();
        return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we, bus.pc_src, bus.reg_write,
                bus.alu_srca, bus.alu_srcb, bus.alu_ctrl, bus.imm_src, bus.result_src,
                bus.illegal, bus.bus_err};
    endfunction

    // One cycle: apply reset and memory response at negedge, sample outputs just after.
    task automatic tick();
        @(negedge clk);
        rst = rst_nx;
        if (rst && bus.mem_req) begin
            if (!busy) begin
                busy = 1;
                rem = hang ? (1 << 20) : (fix_wait >= 0 ? fix_wait : int'($urandom_range(0, 3)));
                cur_wait = rem;
            end
            bus.mem_ready = (rem == 0);
            if (rem > 0) rem--;
        end else begin
            busy = 0;
            bus.mem_ready = 1'b0;
        end
        #1;
        if (prev_wait && rst && !bus.bus_err)
            chk("req_stable", 32'({bus.mem_req, bus.iord, bus.mem_we}), 32'(prev_rq));
        prev_wait = rst && bus.mem_req && !bus.mem_ready;
        prev_rq = {bus.mem_req, bus.iord, bus.mem_we};
        if (bus.mem_req && bus.mem_ready) busy = 0;
    endtask

    task automatic do_reset();
        rst_nx = 1'b0;
        tick();
        tick();
        rst_nx = 1'b1;
        tick();
    endtask

    // ---------------- instruction-level reference model ----------------
    int          cls;
    logic [31:0] cur;
    logic        zcur;
    int          cyc, nwr, npc, nacc, data_w, fetch_w;
    logic [1:0]  wr_src;
    logic        pcsrc_seen, acc_we;
    logic [2:0]  alu_seen;

    task automatic gen_instr(output int c, output logic [31:0] w);
        logic [2:0] okf3 [4];
        okf3 = '{3'd0, 3'd7, 3'd6, 3'd2};
        c = int'($urandom_range(0, 5));
        w = $urandom;
        case (c)
            0: begin w[6:0] = 7'b0110011; w[14:12] = okf3[$urandom_range(0, 3)]; end
            1: begin w[6:0] = 7'b0010011; w[14:12] = okf3[$urandom_range(0, 3)]; end
            2: begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
            3: begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
            4: begin w[6:0] = 7'b1100011; w[14:12] = {2'b00, 1'($urandom_range(0, 1))}; end
            default: w[6:0] = 7'b1101111;
        endcase
    endtask

    function automatic logic [2:0] exp_alu(int c, logic [31:0] w);
        if (c == 4) return 3'b001;
        if (c > 1) return 3'b000;
        case (w[14:12])
            3'd7:    return 3'b010;
            3'd6:    return 3'b011;
            3'd2:    return 3'b101;
            default: return (c == 0 && w[30]) ? 3'b001 : 3'b000;
        endcase
    endfunction

    task automatic check_instr();
        int  lat;
        int  ewr, epc, eacc;
        lat  = (cls == 2) ? 5 : (cls >= 4) ? 3 : 4;
        ewr  = (cls == 3 || cls == 4) ? 0 : 1;
        epc  = (cls == 5) ? 1 : (cls == 4) ? int'(cur[12] ? !zcur : zcur) : 0;
        eacc = (cls == 2 || cls == 3) ? 1 : 0;
        chk("lat", 32'(cyc), 32'(lat + data_w + fetch_w));
        chk("nwr", 32'(nwr), 32'(ewr));
        if (ewr == 1) chk("wr_src", 32'(wr_src), (cls == 2) ? 32'd1 : (cls == 5) ? 32'd2 : 32'd0);
        chk("npc", 32'(npc), 32'(epc));
        if (epc == 1) chk("pc_src", 32'(pcsrc_seen), 32'd1);
        chk("nacc", 32'(nacc), 32'(eacc));
        if (eacc == 1) chk("acc_we", 32'(acc_we), (cls == 3) ? 32'd1 : 32'd0);
        if (cls != 5) chk("alu", 32'(alu_seen), 32'(exp_alu(cls, cur)));
        chk("flags", 32'({bus.illegal, bus.bus_err}), 32'd0);
    endtask

    task automatic run_stream(int n);
        int  done = 0;
        int  guard = 0;
        bit  have = 0;
        while (done < n && guard < 20000) begin
            tick();
            guard++;
            if (have) cyc++;
            if (bus.reg_write) begin nwr++; wr_src = bus.result_src; end
            if (bus.pc_we && !bus.ir_we) begin npc++; pcsrc_seen = bus.pc_src; end
            if (bus.alu_srca == 2'b10) alu_seen = bus.alu_ctrl;
            if (bus.mem_req && bus.mem_ready) begin
                if (bus.iord) begin nacc++; acc_we = bus.mem_we; data_w = cur_wait; end
                else fetch_w = cur_wait;
            end
            if (bus.ir_we) begin
                if (have) begin check_instr(); done++; end
                gen_instr(cls, cur);
                zcur = 1'($urandom_range(0, 1));
                bus.instr = cur;
                bus.zero = zcur;
                cyc = 0; nwr = 0; npc = 0; nacc = 0; data_w = 0;
                wr_src = 2'b11; pcsrc_seen = 1'b0; acc_we = 1'b0; alu_seen = 3'b111;
                have = 1;
            end
        end
        chk("stream_done", 32'(done), 32'(n));
    endtask

    initial begin
        logic any_wr;
        bus.instr = 32'h0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;

        // reset state, then release: one IDLE cycle, then FETCH
        for (int i = 0; i < 3; i++) begin tick(); chk("rst_outs", 32'(outs()), 32'd0); end
        bus.instr = 32'h0000A103;
        fix_wait = 0;
        rst_nx = 1'b1;
        tick(); chk("idle_outs", 32'(outs()), 32'd0);
        tick(); chk("fetch_req", 32'({bus.mem_req, bus.iord}), 32'b10);
        // lw into a hanging MEM_RD, then reset mid-wait
        tick(); tick();
        hang = 1;
        tick(); tick();
        chk("mem_rd_req", 32'({bus.mem_req, bus.iord, bus.mem_we}), 32'b110);
        rst_nx = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); chk("rst_midwait", 32'(outs()), 32'd0); end
        hang = 0;
        rst_nx = 1'b1;
        tick(); chk("idle_again", 32'(outs()), 32'd0);
        tick(); chk("fetch_again", 32'({bus.mem_req, bus.iord}), 32'b10);

        // addi x1,x0,5 with zero-wait memory
        do_reset();
        bus.instr = 32'h00500093;
        fix_wait = 0;
        tick(); chk("addi_c1", 32'({bus.ir_we, bus.pc_we, bus.alu_srcb}), 32'b11_10);
        tick(); chk("addi_dec", 32'({bus.alu_srca, bus.alu_srcb, bus.imm_src}), 32'b01_01_10);
        tick(); chk("addi_exec", 32'({bus.alu_srca, bus.alu_srcb, bus.imm_src}), 32'b10_01_00);
        tick(); chk("addi_wb", 32'({bus.reg_write, bus.alu_ctrl, bus.result_src}), 32'b1_000_00);
        tick(); chk("addi_next", 32'({bus.mem_req, bus.iord, bus.ir_we}), 32'b101);

        // lw with three data wait cycles
        do_reset();
        bus.instr = 32'h0000A103;
        fix_wait = 0;
        tick(); tick();
        tick(); chk("lw_adr", 32'({bus.alu_srca, bus.alu_srcb, bus.imm_src}), 32'b10_01_00);
        fix_wait = 3;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lw_req", 32'({bus.mem_req, bus.iord, bus.mem_we, bus.reg_write}), 32'b1100);
        end
        tick(); chk("lw_wb", 32'({bus.reg_write, bus.result_src}), 32'b1_01);
        tick(); chk("lw_next", 32'({bus.mem_req, bus.iord}), 32'b10);

        // beq then bne, both with zero=1
        do_reset();
        bus.instr = 32'h00000063;
        bus.zero = 1'b1;
        fix_wait = 0;
        tick(); tick();
        tick(); chk("beq_taken", 32'({bus.pc_we, bus.pc_src, bus.alu_ctrl}), 32'b1_1_001);
        tick(); chk("beq_next", 32'({bus.mem_req, bus.iord}), 32'b10);
        bus.instr = 32'h00001063;
        tick();
        tick(); chk("bne_not", 32'({bus.pc_we, bus.pc_src}), 32'b01);
        tick(); chk("bne_next", 32'({bus.mem_req, bus.iord}), 32'b10);

        // memory hang: trap after eight wait cycles
        do_reset();
        hang = 1;
        for (int i = 0; i < 8; i++) begin tick(); chk("to_wait", 32'({bus.mem_req, bus.bus_err}), 32'b10); end
        tick(); chk("to_trap", 32'({bus.mem_req, bus.bus_err, bus.illegal}), 32'b010);
        tick(); tick(); chk("to_sticky", 32'({bus.mem_req, bus.bus_err}), 32'b01);
        hang = 0;
        do_reset();
        chk("to_cleared", 32'(bus.bus_err), 32'd0);
        // ready on the last allowed cycle completes normally
        bus.instr = 32'h00500093;
        fix_wait = 7;
        for (int i = 0; i < 8; i++) tick();
        chk("to_edge_hs", 32'({bus.ir_we, bus.bus_err}), 32'b10);
        tick(); chk("to_edge_dec", 32'({bus.alu_srca, bus.bus_err}), 32'b01_0);

        // illegal opcode and illegal R-type funct3
        do_reset();
        bus.instr = 32'h0000007F;
        fix_wait = 0;
        any_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); any_wr |= bus.reg_write; end
        chk("ill_op", 32'({bus.illegal, bus.mem_req, any_wr}), 32'b100);
        do_reset();
        bus.instr = 32'h00001033;
        any_wr = 1'b0;
        tick(); tick();
        tick(); chk("ill_r_exec", 32'(bus.illegal), 32'd0);
        for (int i = 0; i < 4; i++) begin tick(); any_wr |= bus.reg_write; end
        chk("ill_r", 32'({bus.illegal, bus.bus_err, bus.mem_req, any_wr}), 32'b1000);

        // random instruction stream with random memory latency
        do_reset();
        fix_wait = -1;
        run_stream(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
